// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow FF.
// Define SERIAL_SUB_ADD_MODE_EN to add a mode port selecting add (1) or subtract (0).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] rsh;
  logic             bw;
  logic [CW-1:0]    cnt;
  logic             add_op;
  logic             x;
  logic             y;
  logic             d;
  logic             nb;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic md;
  assign add_op = md;
`else
  assign add_op = 1'b0;
`endif

  // One cell: difference/sum bit and next borrow/carry for the current LSBs
  always_comb begin
    x  = sa[0];
    y  = sb[0];
    d  = x ^ y ^ bw;
    nb = add_op ? ((x & y) | (bw & (x ^ y)))
                : ((~x & y) | (~(x ^ y) & bw));
  end

  // Control FSM and datapath; result is published only on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      rsh        <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      md         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bw    <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_ADD_MODE_EN
            md    <= mode;
`endif
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          rsh <= {d, rsh[WIDTH-1:1]};
          bw  <= nb;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff       <= {d, rsh[WIDTH-1:1]};
            borrow_out <= nb;
            done       <= 1'b1;
            state      <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Hand-computed vectors; checks latency, hold, ignored start, reset, streaming.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrow_in;
  logic [7:0] diff;
  logic       borrow_out;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic       mode;
`endif

  int tests;
  int fails;
  int done_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode       (mode),
`endif
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tbv,
                    input logic tbin, input logic tmode,
                    input logic [7:0] ed, input logic eb,
                    input int poke, input string tag);
    int d0;
    @(negedge clk);
    a = ta;
    b = tbv;
    borrow_in = tbin;
    start = 1'b1;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode = tmode;
`else
    if (tmode) $display("[TB] mode ignored in subtract-only build");
`endif
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tbv;
    borrow_in = ~tbin;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_done0"}, done, 0);
    for (int k = 1; k < 8; k++) begin
      if (k == poke) begin
        start = 1'b1;
        a = 8'h00;
        b = 8'h00;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_done_early"}, done, 0);
      chk({tag, "_busy_mid"}, busy, 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, borrow_out, eb);
    @(negedge clk);
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_diff_hold"}, diff, ed);
    chk({tag, "_bout_hold"}, borrow_out, eb);
    chk({tag, "_one_pulse"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int last_t;
    bit seen;
    tests = 0;
    fails = 0;
    done_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    borrow_in = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode = 1'b0;
`endif
    #1;
    chk("rst_diff", diff, 0);
    chk("rst_bout", borrow_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    op(8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 0, "5m3");
    op(8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 0, "3m5");
    op(8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 0, "0m0b");
    op(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 0, "FFmFF");
    op(8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 3, "ign");

    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    borrow_in = 1'b0;
    start = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_diff", diff, 0);
    chk("arst_bout", borrow_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_idle", busy, 0);
    op(8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0, 0, "post_rst");

    @(negedge clk);
    a = 8'h09;
    b = 8'h04;
    borrow_in = 1'b0;
    start = 1'b1;
    d0 = done_cnt;
    seen = 1'b0;
    last_t = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (seen) chk("strm_stable", diff, 8'h05);
      if (done) begin
        chk("strm_diff", diff, 8'h05);
        if (seen) chk("strm_period", t - last_t, 10);
        else chk("strm_first", t, 8);
        seen = 1'b1;
        last_t = t;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("strm_pulses", done_cnt - d0, 3);

`ifdef SERIAL_SUB_ADD_MODE_EN
    op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 0, "addFF1");
    op(8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0, 0, "add1234");
    op(8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 0, "mode0");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor built around one full-subtractor cell and a borrow flip-flop; computes a - b - borrow_in LSB-first, one bit per clock.
- Counterpart to the team's combinational full adder: this block subtracts instead of adds, and iterates one cell over time instead of replicating it.
- Used as the area-minimal arithmetic unit in the sequential datapath labs; start/busy/done handshake toward the controller.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- borrow_in  input  1  initial borrow; captured on accepted start
- diff  output  WIDTH  result; valid from done until next accepted start
- borrow_out  output  1  final borrow (1 = a < b + borrow_in, unsigned)
- busy  output  1  high in SHIFT and DONE
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset: async on rst high. State=IDLE; diff=0, borrow_out=0, busy=0, done=0; shift registers, bit counter and borrow FF cleared. Applies at any time, including mid-operation; partial result is discarded, no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at a rising edge: load sa<=a, sb<=b, bw<=borrow_in, cnt<=0, go to SHIFT. Accepting edge = edge 0.
- SHIFT (edges 1..WIDTH), per edge:
  - x=sa[0], y=sb[0]
  - d = x ^ y ^ bw
  - bw <= (~x & y) | (~(x ^ y) & bw)
  - sa and sb shift right one place
  - d shifts into the result register from the MSB side, so after WIDTH shifts bit i of diff = bit i of the difference
  - cnt increments
  - When cnt = WIDTH-1 at an edge (edge WIDTH): perform the final bit, go to DONE.
- DONE: lasts exactly one cycle (between edge WIDTH and edge WIDTH+1). done=1, busy=1. diff and borrow_out are final. Next edge returns to IDLE.
- Latency: done high WIDTH cycles after the accepting edge. Throughput: one operation per WIDTH+2 cycles.
- start is ignored in SHIFT and DONE. It has no effect and is not queued. Changes to a, b and borrow_in after acceptance have no effect.
- diff and borrow_out hold their value in IDLE until the next accepted start.
- diff may show partial values during SHIFT; consumers use it only at or after done.
- Arithmetic: modulo 2^WIDTH. borrow_out is the borrow out of the MSB. No signed overflow flag.
- start held high continuously: a new operation is accepted at every IDLE edge, i.e. back-to-back every WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- Defined:
  - Adds input port mode (1 bit), captured on accepted start.
  - mode=0: behaviour exactly as above.
  - mode=1: the cell becomes a full adder. d = x^y^c, c <= (x&y)|(c&(x^y)). borrow_in acts as carry-in, borrow_out reports carry-out, diff reports the sum.
- Undefined: no mode port; subtract only. Logic is identical to mode=0.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, borrow_in=0, start pulse -> busy high from edge 0; done high one cycle after edge 8; diff=0x02, borrow_out=0.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1. Then a=0xFF, b=0xFF, borrow_in=0 -> diff=0x00, borrow_out=0.
- Start a=0x80, b=0x01; pulse start again with a=0x00, b=0x00 at edge 4 -> second start ignored; diff=0x7F, borrow_out=0; exactly one done pulse.
- Start a=0xAA, b=0x55; assert rst between edges 3 and 4 (async, mid-cycle) -> outputs 0 immediately, state IDLE; no done pulse. After release, a=0x10, b=0x01 -> diff=0x0F.
- start held high for 30 cycles with a=0x09, b=0x04 -> done pulses exactly every 10 cycles; diff=0x05 each time; diff stable between pulses.
- With SERIAL_SUB_ADD_MODE_EN, mode=1, a=0xFF, b=0x01, borrow_in=0 -> diff=0x00, borrow_out=1. Then mode=1, a=0x12, b=0x34, borrow_in=1 -> diff=0x47, borrow_out=0.
